// File: rtl/rv_pipe_pkg.sv
// -----------------------------------------------------------------------------
// rv_pipe_pkg
// Shared RV32 pipeline definitions used by the hazard/forwarding logic.
// Contents:
//   - Base opcode constants (OPC_LUI ... OPC_REG) and the M-extension funct7.
//   - Operand select encodings (opsel_e) for the X-stage ALU input muxes.
//   - NOP_INSN, the canonical bubble (addi x0,x0,0).
//   - shadow_t, the decoded fields each X/M/W shadow stage keeps.
//   - Decode helpers: is_writer(), writes_rd(), uses_rs1(), uses_rs2().
// -----------------------------------------------------------------------------
package rv_pipe_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_REG    = 7'b0110011;

  // funct7 that turns an OP (register-register) instruction into MUL/DIV.
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // X-stage operand selects. For operand A, SEL_PCIMM picks the PC; for
  // operand B it picks the immediate.
  typedef enum logic [1:0] {
    SEL_REG   = 2'b00,
    SEL_PCIMM = 2'b01,
    SEL_MX    = 2'b10,
    SEL_WX    = 2'b11
  } opsel_e;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  // Only the fields the hazard logic needs from an older instruction.
  typedef struct packed {
    logic       valid;
    logic [6:0] opcode;
    logic [4:0] rd;
  } shadow_t;

  function automatic logic is_writer(input logic [6:0] opcode);
    return opcode inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
                          OPC_LOAD, OPC_OP_IMM, OPC_REG};
  endfunction

  // A stage produces a forwardable result only if it is real, writes the
  // register file and does not target x0.
  function automatic logic writes_rd(input shadow_t s);
    return s.valid && is_writer(s.opcode) && (s.rd != 5'd0);
  endfunction

  function automatic logic uses_rs1(input logic [6:0] opcode);
    return opcode inside {OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE,
                          OPC_OP_IMM, OPC_REG};
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opcode);
    return opcode inside {OPC_BRANCH, OPC_STORE, OPC_REG};
  endfunction

endpackage : rv_pipe_pkg

// File: rtl/muldiv_latency_ctr.sv
// -----------------------------------------------------------------------------
// muldiv_latency_ctr
// Down-counter that holds a multi-cycle MUL/DIV in Execute. Loaded with
// (latency-1) when such an op enters X; busy while non-zero. The op's result
// is valid in the cycle the count reaches zero.
// Ports:
//   clock       in   pipeline clock
//   reset_n     in   synchronous active-low reset (clears the count)
//   load_i      in   an M-op with latency > 1 is entering X this cycle
//   load_val_i  in   remaining busy cycles to load (latency - 1)
//   busy_o      out  count is non-zero; X must hold
// -----------------------------------------------------------------------------
module muldiv_latency_ctr #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             busy_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // load_i is only raised while the count is zero, so load and decrement
  // never compete.
  always_comb begin
    // NOTE: combinational blocks assign a default first and use blocking '=';
    // any path that leaves a variable unassigned would infer a latch.
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking '<=' so every flop samples
  // pre-edge values; the reset here is synchronous, tested inside the edge.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != '0);

endmodule : muldiv_latency_ctr

// File: rtl/hazard_forward_unit.sv
// -----------------------------------------------------------------------------
// hazard_forward_unit
// Decode-stage forwarding and stall generator for the 5-stage RV32 pipeline.
// Keeps decoded X/M/W shadows of older instructions that advance in lockstep
// with the datapath pipeline registers, and compares them against the
// instruction in Decode.
// Ports:
//   clock        in   pipeline clock
//   reset_n      in   synchronous active-low reset
//   insn_d       in   instruction in Decode
//   valid_d      in   insn_d is a real instruction
//   flush_x      in   mispredict: insn_d must not enter X
//   asel         out  operand A select (00 reg, 01 PC, 10 MX, 11 WX)
//   bsel         out  operand B select (00 reg, 01 imm, 10 MX, 11 WX)
//   dmem_wsel    out  store data taken from the W-stage result (WM bypass)
//   a_wd_byp     out  rs1 read replaced by the W result (WD_BYPASS=1 only)
//   b_wd_byp     out  rs2 read replaced by the W result (WD_BYPASS=1 only)
//   stall_d      out  hold F/D; X bubbles (load-use) or holds (busy)
//   muldiv_busy  out  multi-cycle M-op occupying X
// All outputs are combinational and forced low while reset_n is low.
// -----------------------------------------------------------------------------
module hazard_forward_unit #(
  parameter int unsigned MUL_LATENCY = 1,
  parameter int unsigned DIV_LATENCY = 4,
  parameter bit          WD_BYPASS   = 1'b0,
  parameter logic [31:0] NOP_INSN    = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] insn_d,
  input  logic        valid_d,
  input  logic        flush_x,
  output logic [1:0]  asel,
  output logic [1:0]  bsel,
  output logic        dmem_wsel,
  output logic        a_wd_byp,
  output logic        b_wd_byp,
  output logic        stall_d,
  output logic        muldiv_busy
);

  import rv_pipe_pkg::*;

  localparam int unsigned MAX_LATENCY =
    (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
  localparam int unsigned CNT_W = $clog2(MAX_LATENCY) + 1;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LATENCY - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LATENCY - 1);

  localparam shadow_t BUBBLE = '{valid:  1'b0,
                                 opcode: NOP_INSN[6:0],
                                 rd:     NOP_INSN[11:7]};

  // ---------------------------------------------------------------------------
  // Decode-stage fields
  // ---------------------------------------------------------------------------
  logic [6:0] opc_d;
  logic [4:0] rd_d;
  logic [2:0] funct3_d;
  logic [4:0] rs1_d;
  logic [4:0] rs2_d;
  logic [6:0] funct7_d;

  assign opc_d    = insn_d[6:0];
  assign rd_d     = insn_d[11:7];
  assign funct3_d = insn_d[14:12];
  assign rs1_d    = insn_d[19:15];
  assign rs2_d    = insn_d[24:20];
  assign funct7_d = insn_d[31:25];

  logic use_rs1;
  logic use_rs2;
  logic use_rs2_alu;

  assign use_rs1     = uses_rs1(opc_d);
  assign use_rs2     = uses_rs2(opc_d);
  // STORE rs2 is store data and is served by dmem_wsel, never by bsel.
  assign use_rs2_alu = use_rs2 && (opc_d != OPC_STORE);

  // ---------------------------------------------------------------------------
  // Shadow pipeline
  // ---------------------------------------------------------------------------
  shadow_t x_q, m_q, w_q;
  shadow_t x_d, m_d, w_d;

  logic x_wr, m_wr, w_wr;
  logic x_is_load;
  logic x_fwd;

  assign x_wr      = writes_rd(x_q);
  assign m_wr      = writes_rd(m_q);
  assign w_wr      = writes_rd(w_q);
  assign x_is_load = (x_q.opcode == OPC_LOAD);
  // A load in X has no data yet, so it cannot feed MX.
  assign x_fwd     = x_wr && !x_is_load;

  logic hit_x1, hit_m1, hit_w1;
  logic hit_x2, hit_m2, hit_w2;

  assign hit_x1 = x_fwd && (x_q.rd == rs1_d);
  assign hit_m1 = m_wr  && (m_q.rd == rs1_d);
  assign hit_w1 = w_wr  && (w_q.rd == rs1_d);
  assign hit_x2 = x_fwd && (x_q.rd == rs2_d);
  assign hit_m2 = m_wr  && (m_q.rd == rs2_d);
  assign hit_w2 = w_wr  && (w_q.rd == rs2_d);

  // ---------------------------------------------------------------------------
  // Stalls and multi-cycle op tracking
  // ---------------------------------------------------------------------------
  logic             busy;
  logic             load_use;
  logic             stall;
  logic             enter_x;
  logic             is_mop_d;
  logic [CNT_W-1:0] mop_load;
  logic             ctr_load;

  // Busy takes precedence: load-use only counts once the counter is idle.
  // A STORE matching a load only on rs2 is excluded via use_rs2_alu.
  assign load_use = !busy && x_wr && x_is_load &&
                    ((use_rs1 && (x_q.rd == rs1_d)) ||
                     (use_rs2_alu && (x_q.rd == rs2_d)));
  assign stall    = busy || load_use;
  assign enter_x  = valid_d && !flush_x && !stall;

  assign is_mop_d = (opc_d == OPC_REG) && (funct7_d == FUNCT7_MULDIV);
  assign mop_load = funct3_d[2] ? DIV_LOAD : MUL_LOAD;
  // Single-cycle latencies load zero, i.e. never go busy.
  assign ctr_load = enter_x && is_mop_d && (mop_load != '0);

  muldiv_latency_ctr #(
    .CNT_W (CNT_W)
  ) u_muldiv_ctr (
    .clock      (clock),
    .reset_n    (reset_n),
    .load_i     (ctr_load),
    .load_val_i (mop_load),
    .busy_o     (busy)
  );

  always_comb begin
    x_d = x_q;
    m_d = m_q;
    w_d = m_q;
    if (busy) begin
      // The M-op stays in X; M receives a bubble behind it. A flush during
      // this window targets the younger instruction in D, not the op in X.
      m_d = BUBBLE;
    end else begin
      m_d = x_q;
      // Load-use and flush both leave X with a bubble.
      x_d = enter_x ? '{valid: 1'b1, opcode: opc_d, rd: rd_d} : BUBBLE;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      x_q <= BUBBLE;
      m_q <= BUBBLE;
      w_q <= BUBBLE;
    end else begin
      x_q <= x_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Operand selects and bypass enables
  // ---------------------------------------------------------------------------
  opsel_e asel_c;
  opsel_e bsel_c;
  logic   dmem_wsel_c;
  logic   a_wd_c;
  logic   b_wd_c;

  always_comb begin
    if (use_rs1 && hit_x1) begin
      asel_c = SEL_MX;
    end else if (use_rs1 && hit_m1) begin
      asel_c = SEL_WX;
    end else if (opc_d inside {OPC_AUIPC, OPC_JAL, OPC_BRANCH}) begin
      asel_c = SEL_PCIMM;
    end else begin
      asel_c = SEL_REG;
    end
  end

  always_comb begin
    if (use_rs2_alu && hit_x2) begin
      bsel_c = SEL_MX;
    end else if (use_rs2_alu && hit_m2) begin
      bsel_c = SEL_WX;
    end else if (opc_d == OPC_REG) begin
      bsel_c = SEL_REG;
    end else begin
      bsel_c = SEL_PCIMM;
    end
  end

  // WM store-data bypass accepts a load in X: its data arrives in W just in
  // time for the store's memory stage.
  assign dmem_wsel_c = (opc_d == OPC_STORE) && x_wr && (x_q.rd == rs2_d);

  // WD only matters when no younger producer of the same register exists.
  assign a_wd_c = WD_BYPASS && use_rs1 && hit_w1 && !hit_x1 && !hit_m1;
  assign b_wd_c = WD_BYPASS && use_rs2 && hit_w2 && !hit_x2 && !hit_m2;

  always_comb begin
    asel        = '0;
    bsel        = '0;
    dmem_wsel   = 1'b0;
    a_wd_byp    = 1'b0;
    b_wd_byp    = 1'b0;
    stall_d     = 1'b0;
    muldiv_busy = 1'b0;
    if (reset_n) begin
      asel        = asel_c;
      bsel        = bsel_c;
      dmem_wsel   = dmem_wsel_c;
      a_wd_byp    = a_wd_c;
      b_wd_byp    = b_wd_c;
      stall_d     = stall;
      muldiv_busy = busy;
    end
  end

endmodule : hazard_forward_unit
